// File: rtl/rom_loader.sv
// Splits hps_io 16-bit download words into byte writes with a fixed
// two-cycle wait handshake and region-relative ROM addressing.
module rom_loader #(
    parameter logic [23:0] REG1_START = 24'h008000,
    parameter logic [23:0] REG2_START = 24'h010000,
    parameter logic [23:0] REG3_START = 24'h018000,
    parameter logic [23:0] TOTAL_SIZE = 24'h020000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic [3:0]  rom_cs,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_we,
    output logic        loaded,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [26:0] r_addr;
    logic [15:0] r_dout;
    logic        r_wait;
    logic        r_we;
    logic [3:0]  r_cs;
    logic [16:0] r_rom_addr;
    logic [7:0]  r_rom_data;
    logic        r_loaded;
    logic        r_overflow;
    logic        r_dl_d;
    logic        r_done_pend;

    logic        w_emit;
    logic        w_latch;
    logic        w_wait_nxt;
    logic [26:0] w_baddr;
    logic [7:0]  w_bdata;
    logic [3:0]  w_cs;
    logic [16:0] w_off;
    logic        w_hit;
    logic        w_rise;
    logic        w_fall;

    function automatic logic [3:0] f_cs(input logic [26:0] a);
        logic [3:0] cs;
        if (a < {3'b000, REG1_START})      cs = 4'b0001;
        else if (a < {3'b000, REG2_START}) cs = 4'b0010;
        else if (a < {3'b000, REG3_START}) cs = 4'b0100;
        else if (a < {3'b000, TOTAL_SIZE}) cs = 4'b1000;
        else                               cs = 4'b0000;
        return cs;
    endfunction

    // Offsets are computed modulo 2^24 and then cut to the 17-bit ROM bus.
    function automatic logic [16:0] f_off(input logic [26:0] a);
        logic [23:0] d;
        if (a < {3'b000, REG1_START})      d = a[23:0];
        else if (a < {3'b000, REG2_START}) d = a[23:0] - REG1_START;
        else if (a < {3'b000, REG3_START}) d = a[23:0] - REG2_START;
        else                               d = a[23:0] - REG3_START;
        return d[16:0];
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_latch     = 1'b0;
        w_wait_nxt  = r_wait;
        w_baddr     = r_addr;
        w_bdata     = r_dout[7:0];
        case (r_state)
            IDLE: begin
                if (ioctl_wr && ioctl_download) begin
                    w_latch     = 1'b1;
                    w_emit      = 1'b1;
                    w_baddr     = ioctl_addr;
                    w_bdata     = ioctl_dout[7:0];
                    w_wait_nxt  = 1'b1;
                    w_state_nxt = LO;
                end
            end
            LO: begin
                w_emit      = 1'b1;
                w_baddr     = r_addr + 27'd1;
                w_bdata     = r_dout[15:8];
                w_state_nxt = HI;
            end
            HI: begin
                w_wait_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_cs   = f_cs(w_baddr);
    assign w_off  = f_off(w_baddr);
    assign w_hit  = w_emit && (w_cs != 4'b0000);
    assign w_rise = ioctl_download & ~r_dl_d;
    assign w_fall = ~ioctl_download & r_dl_d;

    // The byte registered here is the one presented during the following state.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_dout     <= '0;
            r_wait     <= 1'b0;
            r_we       <= 1'b0;
            r_cs       <= '0;
            r_rom_addr <= '0;
            r_rom_data <= '0;
        end else begin
            if (w_latch) begin
                r_addr <= ioctl_addr;
                r_dout <= ioctl_dout;
            end
            r_wait <= w_wait_nxt;
            r_we   <= w_hit;
            r_cs   <= w_hit ? w_cs : 4'b0000;
            if (w_hit) begin
                r_rom_addr <= w_off;
                r_rom_data <= w_bdata;
            end
        end
    end

    // A falling download edge is held pending until the word in flight drains.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dl_d      <= 1'b0;
            r_done_pend <= 1'b0;
            r_loaded    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_dl_d     <= ioctl_download;
            r_overflow <= (r_overflow & ~w_rise) | (w_emit & ~w_hit);
            if (w_rise) begin
                r_done_pend <= 1'b0;
                r_loaded    <= 1'b0;
            end else if (w_fall) begin
                r_done_pend <= 1'b1;
            end else if (r_state == IDLE && r_done_pend) begin
                r_done_pend <= 1'b0;
                r_loaded    <= ~r_overflow;
            end
        end
    end

    assign ioctl_wait = r_wait;
    assign rom_we     = r_we;
    assign rom_cs     = r_cs;
    assign rom_addr   = r_rom_addr;
    assign rom_data   = r_rom_data;
    assign loaded     = r_loaded;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: default-map instance checked byte by byte,
// small-map instance used for a complete download.
module tb_rom_loader;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wait;
    logic [3:0]  rom_cs;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_we;
    logic        loaded;
    logic        overflow;

    logic        s_wait;
    logic [3:0]  s_cs;
    logic [16:0] s_addr;
    logic [7:0]  s_data;
    logic        s_we;
    logic        s_loaded;
    logic        s_overflow;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int s_we_cnt = 0;
    logic [60:0] exp_q[$];

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc = cyc + 1;

    rom_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_we(rom_we), .loaded(loaded), .overflow(overflow)
    );

    rom_loader #(
        .REG1_START(24'h000040), .REG2_START(24'h000080),
        .REG3_START(24'h0000C0), .TOTAL_SIZE(24'h000100)
    ) dut_s (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(s_wait), .rom_cs(s_cs), .rom_addr(s_addr),
        .rom_data(s_data), .rom_we(s_we), .loaded(s_loaded), .overflow(s_overflow)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode of the default memory map: {cs, offset}.
    function automatic logic [20:0] ref_map(input logic [26:0] a);
        logic [23:0] a24;
        logic [23:0] o;
        logic [3:0]  cs;
        a24 = a[23:0];
        if (a < 27'h008000)      begin cs = 4'b0001; o = a24; end
        else if (a < 27'h010000) begin cs = 4'b0010; o = a24 - 24'h008000; end
        else if (a < 27'h018000) begin cs = 4'b0100; o = a24 - 24'h010000; end
        else if (a < 27'h020000) begin cs = 4'b1000; o = a24 - 24'h018000; end
        else                     begin cs = 4'b0000; o = 24'h0; end
        return {cs, o[16:0]};
    endfunction

    always @(negedge clk_sys) begin
        if (s_we) s_we_cnt = s_we_cnt + 1;
        if (!reset) begin
            if (rom_we) begin
                if (exp_q.size() == 0) check_val("spurious_we", 64'(rom_we), 64'd0);
                else check_val("byte", 64'({32'(cyc), rom_cs, rom_addr, rom_data}), 64'(exp_q.pop_front()));
            end else begin
                check_val("cs_without_we", 64'(rom_cs), 64'd0);
            end
        end
    end

    // Called just after a negedge; returns at the negedge where the next word may be driven.
    task automatic send_word(input logic [26:0] a, input logic [15:0] d, input bit drop, output int nwait);
        logic [20:0] m0;
        logic [20:0] m1;
        int c0;
        c0 = cyc;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (ioctl_download) begin
            m0 = ref_map(a);
            m1 = ref_map(a + 27'd1);
            if (m0[20:17] != 4'b0000) exp_q.push_back({32'(c0 + 1), m0, d[7:0]});
            if (m1[20:17] != 4'b0000) exp_q.push_back({32'(c0 + 2), m1, d[15:8]});
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        if (drop) ioctl_download = 1'b0;
        nwait = 0;
        while (ioctl_wait && nwait < 10) begin
            nwait++;
            @(negedge clk_sys);
        end
        if (nwait >= 10) check_val("wait_timeout", 64'(ioctl_wait), 64'd0);
    endtask

    initial begin
        int nw;
        int base;
        int k;
        repeat (2) @(negedge clk_sys);
        check_val("rst_wait", 64'(ioctl_wait), 64'd0);
        check_val("rst_we", 64'(rom_we), 64'd0);
        check_val("rst_cs", 64'(rom_cs), 64'd0);
        check_val("rst_addr", 64'(rom_addr), 64'd0);
        check_val("rst_data", 64'(rom_data), 64'd0);
        check_val("rst_loaded", 64'(loaded), 64'd0);
        check_val("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // Write strobe without an active download must be ignored.
        send_word(27'h000000, 16'hFFFF, 1'b0, nw);
        check_val("wr_no_download_wait", 64'(nw), 64'd0);

        ioctl_download = 1'b1;
        @(negedge clk_sys);
        send_word(27'h000000, 16'hBEEF, 1'b0, nw);
        check_val("wait_cycles", 64'(nw), 64'd2);
        send_word(27'h008000, 16'h1234, 1'b0, nw);
        send_word(27'h017FFE, 16'hA55A, 1'b0, nw);
        send_word(27'h007FFE, 16'h0102, 1'b0, nw);
        send_word(27'h00FFFE, 16'h0304, 1'b0, nw);
        send_word(27'h01FFFE, 16'hC3D2, 1'b0, nw);
        check_val("no_overflow_in_map", 64'(overflow), 64'd0);
        // Download drops together with the last word: both bytes still land.
        send_word(27'h000100, 16'h7788, 1'b1, nw);
        @(negedge clk_sys);
        check_val("loaded_after_fall", 64'(loaded), 64'd1);

        // Out-of-map word sets overflow and blocks loaded.
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        check_val("loaded_cleared_on_rise", 64'(loaded), 64'd0);
        send_word(27'h020000, 16'h5AA5, 1'b0, nw);
        check_val("overflow_set", 64'(overflow), 64'd1);
        send_word(27'h000010, 16'h6655, 1'b0, nw);
        ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_val("loaded_blocked", 64'(loaded), 64'd0);
        check_val("overflow_sticky", 64'(overflow), 64'd1);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        check_val("overflow_cleared_on_rise", 64'(overflow), 64'd0);
        ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_val("loaded_clean", 64'(loaded), 64'd1);

        // Reset while the low byte is on the bus aborts the high byte.
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        ioctl_addr = 27'h000020;
        ioctl_dout = 16'h4433;
        ioctl_wr   = 1'b1;
        exp_q.push_back({32'(cyc + 1), 4'b0001, 17'h00020, 8'h33});
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_we", 64'(rom_we), 64'd0);
        check_val("async_rst_cs", 64'(rom_cs), 64'd0);
        check_val("async_rst_wait", 64'(ioctl_wait), 64'd0);
        check_val("async_rst_addr", 64'(rom_addr), 64'd0);
        check_val("async_rst_data", 64'(rom_data), 64'd0);
        check_val("async_rst_loaded", 64'(loaded), 64'd0);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_val("post_rst_wait", 64'(ioctl_wait), 64'd0);

        // Complete download into the small map, every wait honoured.
        ioctl_download = 1'b1;
        base = s_we_cnt;
        @(negedge clk_sys);
        for (int i = 0; i < 128; i++)
            send_word(27'(2 * i), {8'(i), ~8'(i)}, 1'b0, nw);
        ioctl_download = 1'b0;
        k = 0;
        while (!s_loaded && k < 8) begin
            k++;
            @(negedge clk_sys);
        end
        check_val("full_we_count", 64'(s_we_cnt - base), 64'd256);
        check_val("full_loaded", 64'(s_loaded), 64'd1);
        check_val("full_overflow", 64'(s_overflow), 64'd0);

        repeat (3) @(negedge clk_sys);
        check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
- REQ-001 The block SHALL have parameters REG1_START, default 24'h008000, start of the sprite/tile ROM region (byte address).
- REQ-002 The block SHALL have parameter REG2_START, default 24'h010000, start of the sound ROM region.
- REQ-003 The block SHALL have parameter REG3_START, default 24'h018000, start of the MCU/PROM region.
- REQ-004 The block SHALL have parameter TOTAL_SIZE, default 24'h020000, the first byte address past the last region.
- REQ-005 The block SHALL have port clk_sys, input, 1, system clock; every register is clocked on its rising edge.
- REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-007 The block SHALL have port ioctl_download, input, 1, high for the duration of a ROM download; the parent gates it by index 0.
- REQ-008 The block SHALL have port ioctl_wr, input, 1, single-cycle strobe marking one 16-bit word.
- REQ-009 The block SHALL have port ioctl_addr, input, 27, byte address of the word, always even.
- REQ-010 The block SHALL have port ioctl_dout, input, 16, word data: [7:0] is the byte at addr, [15:8] is the byte at addr+1.
- REQ-011 The block SHALL have port ioctl_wait, output, 1, backpressure to hps_io.
- REQ-012 The block SHALL have port rom_cs, output, 4, one-hot region select: bit0 program, bit1 gfx, bit2 sound, bit3 MCU/PROM.
- REQ-013 The block SHALL have port rom_addr, output, 17, byte offset within the selected region.
- REQ-014 The block SHALL have port rom_data, output, 8, byte to write.
- REQ-015 The block SHALL have port rom_we, output, 1, single-cycle write strobe.
- REQ-016 The block SHALL have port loaded, output, 1, high once a download has completed without overflow.
- REQ-017 The block SHALL have port overflow, output, 1, sticky flag: a byte was addressed at or beyond TOTAL_SIZE.

Function
- REQ-018 The FSM SHALL have three states: IDLE, LO, HI.
- REQ-019 IDLE: on ioctl_wr with ioctl_download high, the block SHALL latch ioctl_addr and ioctl_dout, assert ioctl_wait in the next cycle, and go to LO.
- REQ-020 LO: the block SHALL emit the low byte at the latched addr (rom_we=1 for one cycle) and go to HI.
- REQ-021 HI: the block SHALL emit the high byte at addr+1, deassert ioctl_wait at the end of that cycle, and go to IDLE.
- REQ-022 Latency SHALL be fixed: byte writes occur 1 and 2 cycles after ioctl_wr; the next ioctl_wr is accepted 3 cycles after the previous one at the earliest.
- REQ-023 ioctl_wr arriving in LO or HI SHALL be ignored; the wait handshake prevents this case.
- REQ-024 Region decode for byte address a: a<REG1_START -> cs0, offset a; a<REG2_START -> cs1, offset a-REG1_START; a<REG3_START -> cs2, offset a-REG2_START; a<TOTAL_SIZE -> cs3, offset a-REG3_START.
- REQ-025 Region decode SHALL be registered alongside rom_data, so rom_cs, rom_addr and rom_data are valid in the same cycle as rom_we.
- REQ-026 When a≥TOTAL_SIZE, the byte SHALL be dropped: rom_we=0, rom_cs=0, and overflow is set.
- REQ-027 The subtraction in REQ-024 SHALL be 24-bit with the result truncated to 17 bits.
- REQ-028 rom_cs SHALL be all zeros whenever rom_we=0.
- REQ-029 A rising edge of ioctl_download SHALL clear loaded and overflow.
- REQ-030 A falling edge of ioctl_download SHALL set loaded=~overflow once the FSM reaches IDLE; a falling edge that occurs mid-word SHALL still complete the pending bytes first.
- REQ-031 ioctl_wr received while ioctl_download is low SHALL be ignored.

Reset
- REQ-032 On reset assertion, regardless of clock, the block SHALL force: FSM=IDLE, ioctl_wait=0, rom_we=0, rom_cs=0, rom_addr=0, rom_data=0, loaded=0, overflow=0, edge-detect register=0.
- REQ-033 Reset asserted mid-word SHALL abort the pending bytes with no further rom_we.

Verification
- REQ-034 ioctl_wr at addr 0x000000 with dout 0xBEEF -> cycle+1: cs=0001, addr 0, data 0xEF, we; cycle+2: addr 1, data 0xBE, we; wait high for exactly 2 cycles.
- REQ-035 ioctl_wr at addr 0x008000 with dout 0x1234 -> cs=0010, offsets 0 and 1, data 0x34 then 0x12; at addr 0x017FFE -> cs=0100, offsets 0x7FFE and 0x7FFF.
- REQ-036 ioctl_wr at addr 0x020000 -> no rom_we, overflow=1; after download falls, loaded stays 0; the next download rise clears overflow.
- REQ-037 A full download of 0x20000 bytes with wait honoured -> exactly 0x20000 rom_we pulses and loaded=1 one cycle after the FSM returns to IDLE.
- REQ-038 ioctl_download falls in the same cycle as the last ioctl_wr -> both bytes are written, then loaded=1.
- REQ-039 Reset pulsed in LO state -> no HI write occurs; all outputs are 0 immediately, before the next clock edge.
